writeback_regfile: RTL
======================

Name: writeback_regfile

Overview:
- Write-back stage and architectural register file for the Y86-64 core; the write side of the register interface whose read side is the decode stage.
- Holds registers 0..14 and presents them on reg0..reg14 for decode to read.
- From icode/rA/rB/cnd it selects destinations dstE/dstM and commits valE/valM on the clock edge.
- Tracks processor run/halt status.

Parameters:
- DATA_W, 64, register width.
- STACK_INIT, 64'h0000_0000_0000_0200, reset value of %rsp (reg4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wb_en  in  1  write-back valid; the instruction on icode/rA/rB/cnd/valE/valM commits this cycle.
- icode  in  4  instruction code.
- rA  in  4  register field A.
- rB  in  4  register field B.
- cnd  in  1  condition result for cmovxx.
- valE  in  DATA_W  ALU result.
- valM  in  DATA_W  memory read result.
- reg0..reg14  out  DATA_W each  current register contents.
- dstE  out  4  selected E destination; 4'hF means none.
- dstM  out  4  selected M destination; 4'hF means none.
- halted  out  1  sticky: processor stopped.
- err  out  1  sticky: stopped on an invalid icode.

Behaviour:
- Reset: on a clk edge with rst_n=0, reg0..reg14 = 0 except reg4 = STACK_INIT; state = RUN; halted = 0; err = 0. Reset overrides every other input, including mid-halt and while wb_en=1.
- dstE, combinational from icode/rB/cnd:
  - OPq (6) and irmovq (3) -> rB.
  - cmovxx (2) -> rB if cnd=1, else F.
  - pushq (A), popq (B), call (8), ret (9) -> 4.
  - All other icodes -> F.
- dstM, combinational from icode/rA:
  - mrmovq (5) and popq (B) -> rA.
  - All other icodes -> F.
- State machine RUN/HALTED:
  - RUN, wb_en=1, icode=0 (halt): go to HALTED, halted=1, no register write.
  - RUN, wb_en=1, icode>4'hB: go to HALTED, halted=1, err=1, no register write.
  - HALTED: all writes blocked, wb_en ignored; only reset exits.
- Commit, in RUN with wb_en=1 and a valid non-halt icode:
  - If dstE != F, regs[dstE] <= valE.
  - If dstM != F, regs[dstM] <= valM.
  - If dstE == dstM (e.g. popq %rsp), valM wins.
- Register index F is never written. rA/rB = F on an icode that selects them yields no write.
- wb_en=0: no state change; dstE/dstM still reflect the inputs.
- Latency: a value committed at edge N is visible on regX after edge N, so decode sees it in cycle N+1. There is no internal forwarding.
- halted/err assert in the cycle after the halting edge and hold until reset.
- Data is full DATA_W; there is no truncation or extension.

Decomposition:
- Shared package y86_pkg:
  - icode constants I_HALT, I_NOP, I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OPQ, I_JXX, I_CALL, I_RET, I_PUSH, I_POP.
  - R_RSP=4 and R_NONE=4'hF.
  - State enum wb_state_t {RUN, HALTED}.
- One sub-module, wb_dst_sel: combinational icode/rA/rB/cnd -> dstE/dstM. Decode-side hazard logic can reuse it.

Test Plan:
- Reset then idle: rst_n=0 for 1 edge -> reg4=64'h200, all other regs 0, halted=0, err=0. Then wb_en=0 for 5 cycles -> no change.
- irmovq rB=3, valE=64'h1234, wb_en=1 -> reg3=64'h1234 in the next cycle. Then cmovxx rB=5, cnd=0 -> dstE=F and reg5 unchanged. Then cnd=1, valE=7 -> reg5=7.
- popq rA=4, valE=64'h208, valM=64'hBEEF -> dstE=dstM=4 and reg4=64'hBEEF (M priority). Then popq rA=2, valE=64'h210, valM=9 -> reg2=9, reg4=64'h210.
- halt icode=0, wb_en=1 -> halted=1, err=0. Then irmovq rB=1, valE=5 -> reg1 unchanged.
- icode=4'hC, wb_en=1 -> halted=1, err=1, no register write.
- Reset while HALTED, with wb_en=1 and icode=3 on the same edge -> state RUN, halted=0, err=0, regs at reset values (the write is discarded).

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and write-back state type.
package y86_pkg;
  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;
  localparam int         NUM_REGS = 15;

  typedef enum logic {RUN, HALTED} wb_state_t;
endpackage

// File: rtl/wb_dst_sel.sv
// Destination register select for E and M write ports; shared with decode hazard logic.
module wb_dst_sel
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       cnd,
  output logic [3:0] dstE,
  output logic [3:0] dstM
);
  always_comb begin
    dstE = R_NONE;
    case (icode)
      I_OPQ, I_IRMOV:               dstE = rB;
      I_CMOV:                       dstE = cnd ? rB : R_NONE;
      I_PUSH, I_POP, I_CALL, I_RET: dstE = R_RSP;
      default:                      dstE = R_NONE;
    endcase
  end

  always_comb begin
    dstM = R_NONE;
    case (icode)
      I_MRMOV, I_POP: dstM = rA;
      default:        dstM = R_NONE;
    endcase
  end
endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: architectural register file plus run/halt status.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int               DATA_W     = 64,
  parameter logic [DATA_W-1:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic [DATA_W-1:0] reg8,
  output logic [DATA_W-1:0] reg9,
  output logic [DATA_W-1:0] reg10,
  output logic [DATA_W-1:0] reg11,
  output logic [DATA_W-1:0] reg12,
  output logic [DATA_W-1:0] reg13,
  output logic [DATA_W-1:0] reg14,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic              halted,
  output logic              err
);
  logic [NUM_REGS-1:0][DATA_W-1:0] rf;
  wb_state_t state;

  wb_dst_sel u_dst_sel (
    .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .dstE(dstE), .dstM(dstM)
  );

  // dstM is checked first so a popq %rsp keeps the loaded value over the increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      halted <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= (4'(i) == R_RSP) ? STACK_INIT : '0;
    end else if (state == RUN && wb_en) begin
      if (icode == I_HALT) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else if (icode > I_POP) begin
        state  <= HALTED;
        halted <= 1'b1;
        err    <= 1'b1;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (dstM == 4'(i))      rf[i] <= valM;
          else if (dstE == 4'(i)) rf[i] <= valE;
        end
      end
    end
  end

  assign reg0  = rf[0];
  assign reg1  = rf[1];
  assign reg2  = rf[2];
  assign reg3  = rf[3];
  assign reg4  = rf[4];
  assign reg5  = rf[5];
  assign reg6  = rf[6];
  assign reg7  = rf[7];
  assign reg8  = rf[8];
  assign reg9  = rf[9];
  assign reg10 = rf[10];
  assign reg11 = rf[11];
  assign reg12 = rf[12];
  assign reg13 = rf[13];
  assign reg14 = rf[14];
endmodule
